// File: rtl/core_pkg.sv
// Shared core constants and types for the writeback stage.
package core_pkg;

  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned RD_W      = $clog2(NUM_REGS);

  // Load funct3 encodings
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } ld_funct3_e;

  // Which channel received the most recent grant
  typedef enum logic {
    GrantAlu = 1'b0,
    GrantLd  = 1'b1
  } grant_e;

endpackage

// File: rtl/writeback_unit_if.sv
// Result channels, issue port and register-file write bus of the writeback stage.
interface writeback_unit_if
  import core_pkg::*;
();

  logic                 alu_valid;
  logic                 alu_ready;
  logic [RD_W-1:0]      alu_rd;
  logic [WORD_SIZE-1:0] alu_data;

  logic                 ld_valid;
  logic                 ld_ready;
  logic [RD_W-1:0]      ld_rd;
  logic [2:0]           ld_funct3;
  logic [1:0]           ld_offset;
  logic [WORD_SIZE-1:0] ld_word;

  logic                 iss_valid;
  logic [RD_W-1:0]      iss_rd;

  logic [NUM_REGS-1:0]  busy;
  logic                 wenableL [NUM_REGS];
  logic [WORD_SIZE-1:0] data_w   [NUM_REGS];

  // Producers / issue logic / register file side
  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_funct3, ld_offset, ld_word,
    output iss_valid, iss_rd,
    input  alu_ready, ld_ready, busy, wenableL, data_w
  );

  // Writeback stage side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_funct3, ld_offset, ld_word,
    input  iss_valid, iss_rd,
    output alu_ready, ld_ready, busy, wenableL, data_w
  );

endinterface

// File: rtl/load_align.sv
// Combinational load formatter: selects byte/half/word and extends to WORD_SIZE.
module load_align
  import core_pkg::*;
(
  input  logic [2:0]           i_funct3,
  input  logic [1:0]           i_offset,
  input  logic [WORD_SIZE-1:0] i_word,
  output logic [WORD_SIZE-1:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection from the little-endian word
  always_comb begin
    w_byte = i_word[7:0];
    case (i_offset)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
  end

  // Extension by load type; unknown types write zero
  always_comb begin
    o_result = '0;
    case (i_funct3)
      LB:      o_result = {{(WORD_SIZE - 8){w_byte[7]}}, w_byte};
      LH:      o_result = {{(WORD_SIZE - 16){w_half[15]}}, w_half};
      LW:      o_result = i_word;
      LBU:     o_result = {{(WORD_SIZE - 8){1'b0}}, w_byte};
      LHU:     o_result = {{(WORD_SIZE - 16){1'b0}}, w_half};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: ALU/load arbitration, registered register-file write port, pending-write
// scoreboard.
module writeback_unit
  import core_pkg::*;
(
  input  logic             clk,
  input  logic             rstL,
  writeback_unit_if.slave  wb
);

  grant_e               r_last_grant;
  logic                 r_wen [NUM_REGS];
  logic [WORD_SIZE-1:0] r_data;
  logic [NUM_REGS-1:0]  r_busy;

  logic                 w_alu_grant;
  logic                 w_ld_grant;
  logic [RD_W-1:0]      w_rd;
  logic [WORD_SIZE-1:0] w_ld_result;
  logic [WORD_SIZE-1:0] w_result;
  logic                 w_write;
  logic [NUM_REGS-1:0]  w_busy_d;

  load_align u_load_align (
    .i_funct3 (wb.ld_funct3),
    .i_offset (wb.ld_offset),
    .i_word   (wb.ld_word),
    .o_result (w_ld_result)
  );

  // Round-robin arbitration; a tie goes to the channel not granted last
  always_comb begin
    w_alu_grant = rstL & wb.alu_valid & (~wb.ld_valid | (r_last_grant == GrantLd));
    w_ld_grant  = rstL & wb.ld_valid & (~wb.alu_valid | (r_last_grant == GrantAlu));
    w_rd        = w_ld_grant ? wb.ld_rd : wb.alu_rd;
    w_result    = w_ld_grant ? w_ld_result : wb.alu_data;
    w_write     = (w_alu_grant | w_ld_grant) & (w_rd != '0);
  end

  assign wb.alu_ready = w_alu_grant;
  assign wb.ld_ready  = w_ld_grant;

  // Remember the last granted channel; only real grants move it
  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      r_last_grant <= GrantAlu;
    end else if (w_ld_grant) begin
      r_last_grant <= GrantLd;
    end else if (w_alu_grant) begin
      r_last_grant <= GrantAlu;
    end
  end

  // Registered write port: one-cycle strobe per accepted write, data held when idle
  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_wen[i] <= 1'b1;
      r_data <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_wen[i] <= 1'b1;
      if (w_write) begin
        r_wen[w_rd] <= 1'b0;
        r_data      <= w_result;
      end
    end
  end

  // Scoreboard next state: clear on the landing write, then set from issue so set wins
  always_comb begin
    w_busy_d = r_busy;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (!r_wen[i]) w_busy_d[i] = 1'b0;
    end
    if (wb.iss_valid && (wb.iss_rd != '0)) w_busy_d[wb.iss_rd] = 1'b1;
    w_busy_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  assign wb.busy     = r_busy;
  assign wb.wenableL = r_wen;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_data_w
    assign wb.data_w[g] = r_data;
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with hand-computed expected values.
module tb_writeback_unit;
  import core_pkg::*;

  logic clk;
  logic rstL;
  int   n_checks;
  int   n_fails;

  writeback_unit_if wb_if ();

  writeback_unit dut (
    .clk  (clk),
    .rstL (rstL),
    .wb   (wb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load vectors against word 0x80FF7F01
  logic [2:0]  lv_f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
  logic [1:0]  lv_off [6] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd0};
  logic [31:0] lv_exp [6] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01,
                              32'h80FF7F01, 32'h00000000};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wen_mask();
    logic [31:0] m;
    for (int i = 0; i < NUM_REGS; i++) m[i] = wb_if.wenableL[i];
    return m;
  endfunction

  function automatic logic [31:0] onehot_low(input int rd);
    logic [31:0] m;
    m = '1;
    m[rd] = 1'b0;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input int rd, input logic [31:0] data);
    check_val({tag, " wen"}, wen_mask(), onehot_low(rd));
    check_val({tag, " data_rd"}, wb_if.data_w[rd], data);
    check_val({tag, " data_0"}, wb_if.data_w[0], data);
    check_val({tag, " data_31"}, wb_if.data_w[31], data);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rstL = 1'b0;
    wb_if.alu_valid = 1'b1;
    wb_if.alu_rd    = 5'd4;
    wb_if.alu_data  = 32'h11111111;
    wb_if.ld_valid  = 1'b0;
    wb_if.ld_rd     = '0;
    wb_if.ld_funct3 = 3'b010;
    wb_if.ld_offset = '0;
    wb_if.ld_word   = '0;
    wb_if.iss_valid = 1'b0;
    wb_if.iss_rd    = '0;

    // Reset state
    tick();
    tick();
    check_val("reset alu_ready", {31'd0, wb_if.alu_ready}, 32'd0);
    check_val("reset wen", wen_mask(), 32'hFFFFFFFF);
    check_val("reset data", wb_if.data_w[4], 32'd0);
    check_val("reset busy", wb_if.busy, 32'd0);
    @(negedge clk);
    wb_if.alu_valid = 1'b0;
    rstL = 1'b1;

    // ALU only
    @(negedge clk);
    wb_if.alu_valid = 1'b1;
    wb_if.alu_rd    = 5'd5;
    wb_if.alu_data  = 32'hDEADBEEF;
    #1;
    check_val("alu readies", {30'd0, wb_if.alu_ready, wb_if.ld_ready}, 32'd2);
    tick();
    check_write("alu rd5", 5, 32'hDEADBEEF);
    @(negedge clk);
    wb_if.alu_valid = 1'b0;
    tick();
    check_val("idle wen", wen_mask(), 32'hFFFFFFFF);
    check_val("idle data hold", wb_if.data_w[7], 32'hDEADBEEF);

    // Load formatting, back to back
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      wb_if.ld_valid  = 1'b1;
      wb_if.ld_rd     = 5'(10 + k);
      wb_if.ld_funct3 = lv_f3[k];
      wb_if.ld_offset = lv_off[k];
      wb_if.ld_word   = 32'h80FF7F01;
      #1;
      check_val($sformatf("load%0d ready", k), {31'd0, wb_if.ld_ready}, 32'd1);
      tick();
      check_write($sformatf("load%0d", k), 10 + k, lv_exp[k]);
    end
    @(negedge clk);
    wb_if.ld_valid = 1'b0;

    // Scoreboard: set, hold through write, set-wins, then clear
    wb_if.iss_valid = 1'b1;
    wb_if.iss_rd    = 5'd7;
    tick();
    check_val("sb set", wb_if.busy, 32'h00000080);
    @(negedge clk);
    wb_if.iss_valid = 1'b0;
    wb_if.alu_valid = 1'b1;
    wb_if.alu_rd    = 5'd7;
    wb_if.alu_data  = 32'h00000007;
    tick();
    check_val("sb wen7", wen_mask(), onehot_low(7));
    check_val("sb before clear", wb_if.busy, 32'h00000080);
    @(negedge clk);
    wb_if.alu_valid = 1'b0;
    wb_if.iss_valid = 1'b1;
    tick();
    check_val("sb set wins", wb_if.busy, 32'h00000080);
    @(negedge clk);
    wb_if.iss_valid = 1'b0;
    wb_if.alu_valid = 1'b1;
    tick();
    @(negedge clk);
    wb_if.alu_valid = 1'b0;
    wb_if.iss_valid = 1'b1;
    wb_if.iss_rd    = 5'd0;
    tick();
    check_val("sb clear", wb_if.busy, 32'd0);
    @(negedge clk);
    wb_if.iss_rd = 5'd9;
    tick();
    check_val("sb x0 ignored then set9", wb_if.busy, 32'h00000200);

    // rd = 0 write is accepted but nothing lands
    @(negedge clk);
    wb_if.iss_valid = 1'b0;
    wb_if.alu_valid = 1'b1;
    wb_if.alu_rd    = 5'd0;
    wb_if.alu_data  = 32'h12345678;
    #1;
    check_val("rd0 ready", {31'd0, wb_if.alu_ready}, 32'd1);
    tick();
    check_val("rd0 wen", wen_mask(), 32'hFFFFFFFF);
    check_val("rd0 busy", wb_if.busy, 32'h00000200);

    // Contention: last grant is ALU, so load, ALU, load, ALU
    @(negedge clk);
    wb_if.alu_rd    = 5'd1;
    wb_if.alu_data  = 32'hAAAA0001;
    wb_if.ld_valid  = 1'b1;
    wb_if.ld_rd     = 5'd2;
    wb_if.ld_funct3 = 3'b010;
    wb_if.ld_word   = 32'hBBBB0002;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      check_val($sformatf("tie%0d readies", c), {30'd0, wb_if.alu_ready, wb_if.ld_ready},
                (c % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      check_val($sformatf("tie%0d wen", c), wen_mask(), onehot_low((c % 2 == 0) ? 2 : 1));
      check_val($sformatf("tie%0d data", c), wb_if.data_w[0],
                (c % 2 == 0) ? 32'hBBBB0002 : 32'hAAAA0001);
    end
    @(negedge clk);
    wb_if.ld_valid = 1'b0;

    // Asynchronous reset in the cycle after a handshake
    wb_if.alu_rd    = 5'd3;
    wb_if.alu_data  = 32'hCAFEF00D;
    wb_if.iss_valid = 1'b1;
    wb_if.iss_rd    = 5'd3;
    tick();
    check_val("pre-reset wen", wen_mask(), onehot_low(3));
    wb_if.alu_valid = 1'b0;
    wb_if.iss_valid = 1'b0;
    #2;
    rstL = 1'b0;
    #1;
    check_val("async rst wen", wen_mask(), 32'hFFFFFFFF);
    check_val("async rst data", wb_if.data_w[3], 32'd0);
    check_val("async rst busy", wb_if.busy, 32'd0);
    @(negedge clk);
    rstL = 1'b1;
    tick();
    check_val("post-reset wen", wen_mask(), 32'hFFFFFFFF);
    check_val("post-reset data", wb_if.data_w[3], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage directly upstream of the register file. It accepts completed results from the ALU channel and the load channel over valid/ready handshakes, arbitrates between them, sign/zero-extends and aligns load data, and drives the register file's per-register active-low write enables and write-data vector. It also keeps a pending-write scoreboard so issue logic can detect RAW hazards.

## Interface
- NUM_REGS, 32 (package constant): architectural registers; x0 hardwired zero.
- WORD_SIZE, 32 (package constant): datapath width.
- RD_W, $clog2(NUM_REGS): destination index width.
- clk  in  1  clock, all state on rising edge.
- rstL  in  1  reset; **one clock; reset is asynchronous and active-low.**
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  RD_W  ALU destination.
- alu_data  in  WORD_SIZE  ALU result.
- ld_valid  in  1  load response present.
- ld_ready  out  1  load response accepted this cycle.
- ld_rd  in  RD_W  load destination.
- ld_funct3  in  3  load type: LB 000, LH 001, LW 010, LBU 100, LHU 101.
- ld_offset  in  2  byte address bits [1:0].
- ld_word  in  WORD_SIZE  raw aligned memory word, little-endian.
- iss_valid  in  1  an instruction writing a register is issued.
- iss_rd  in  RD_W  its destination.
- busy  out  NUM_REGS  pending-write mask, bit i = xi awaiting writeback.
- wenableL  out  1 x [NUM_REGS]  unpacked per-register write enable, active low.
- data_w  out  WORD_SIZE x [NUM_REGS]  unpacked write data, same value broadcast to every entry.

## Operation
- Arbiter: only ALU valid -> grant ALU; only load valid -> grant load; both valid -> round-robin on last_grant flop (reset value ALU, so load wins first tie). last_grant updates only on an actual grant.
- alu_ready/ld_ready are combinational from valids and last_grant; at most one high per cycle; both 0 while rstL low. The stage never back-pressures beyond arbitration loss.
- Load formatting (sub-module): LB/LBU select byte ld_offset; LH/LHU select half ld_offset[1]; LW whole word, offset ignored. LB/LH sign-extend, LBU/LHU zero-extend. Any other funct3 -> result 0, write still performed.
- Accepted result with rd != 0: next cycle wenableL[rd] = 0, all others 1, data_w[*] = result. rd = 0: handshake completes, all wenableL stay 1, busy untouched.
- Idle cycle (no grant): all wenableL = 1, data_w holds last value.
- Scoreboard: iss_valid with iss_rd != 0 sets busy[iss_rd]; a writeback to rd clears busy[rd] on the edge where wenableL[rd] is low. Same register set and cleared on one edge -> set wins. busy[0] always 0.

## Timing
- Reset (async assert, any time): wenableL all 1, data_w all 0, busy all 0, last_grant = ALU; an accepted-but-unwritten result is dropped.
- Handshake at edge N -> wenableL/data_w registered, valid throughout cycle N+1 -> register file captures at edge N+1 -> busy bit clears at edge N+1.
- Throughput: one writeback per cycle; back-to-back writes to the same rd are legal, later one wins.
- busy is a flop output, no combinational path from inputs.

## Structure
- Shared package core_pkg: WORD_SIZE, NUM_REGS, RD_W, load funct3 enum (LB, LH, LW, LBU, LHU).
- One sub-module: load_align, purely combinational (funct3, offset, word -> WORD_SIZE result).
- Top holds arbiter, last_grant, output registers, scoreboard.

## Test plan
- ALU only: alu_rd=5, alu_data=0xDEADBEEF at edge N -> cycle N+1 wenableL[5]=0, others 1, data_w[*]=0xDEADBEEF.
- Load formatting: ld_word=0x80FF7F01; LB off 3 -> 0xFFFFFF80; LBU off 1 -> 0x0000007F; LH off 2 -> 0xFFFF80FF; LHU off 0 -> 0x00007F01; LW -> 0x80FF7F01.
- Contention: both valid 4 cycles -> grants load, ALU, load, ALU; exactly one ready per cycle.
- rd=0: alu_rd=0 accepted -> ready=1, all wenableL stay 1, busy unchanged.
- Scoreboard: issue rd=7 -> busy[7]=1; writeback rd=7 clears it at edge N+1; issue rd=7 on that same edge -> busy[7] stays 1.
- Reset mid-operation: rstL low asynchronously during cycle N+1 -> wenableL all 1, data_w 0, busy 0 immediately, no write lands.
